fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of the issued-instruction counter.
REQ-002 Port: clk  in  1  single clock for all state; rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-004 Port: start  in  1  one-cycle pulse; begins execution at start_addr.
REQ-005 Port: start_addr  in  16  initial pc, sampled on accepted start.
REQ-006 Port: stall  in  1  downstream not ready; pc and redirects held.
REQ-007 Port: jmp_en  in  1  absolute jump request.
REQ-008 Port: jmp_target  in  16  jump destination.
REQ-009 Port: br_taken  in  1  taken relative branch request.
REQ-010 Port: br_offset  in  8  signed two's-complement branch displacement.
REQ-011 Port: halt  in  1  halt request from decode.
REQ-012 Port: pc  out  16  address presented to the instruction ROM.
REQ-013 Port: pc_valid  out  1  pc holds a live instruction address this cycle.
REQ-014 Port: halted  out  1  block is in HALTED.
REQ-015 Port: issue_cnt  out  CNT_W  count of instructions issued since last start.

Function
REQ-016 States are IDLE, RUN, BUBBLE, HALTED; all state and outputs are registered.
REQ-017 IDLE: pc_valid=0, halted=0, pc holds; start=1 -> RUN, pc<=start_addr, issue_cnt<=0.
REQ-018 RUN: pc_valid=1.
- An "issue" occurs on an edge in RUN with stall=0.
- Redirect/halt inputs are sampled only on issue edges; otherwise ignored.
REQ-019 RUN, issue edge, priority is halt > jmp_en > br_taken > increment.
REQ-020 halt -> HALTED; pc holds.
REQ-021 jmp_en -> BUBBLE; pc<=jmp_target.
REQ-022 br_taken -> BUBBLE; pc<=pc+sign_extend(br_offset), modulo 2^16.
REQ-023 No redirect -> stay RUN; pc<=pc+1, 16'hFFFF wraps to 16'h0000.
REQ-024 RUN with stall=1: pc, state and issue_cnt hold.
REQ-025 BUBBLE: pc_valid=0, pc holds target; next edge -> RUN unconditionally, regardless of stall or any request input.
REQ-026 HALTED: pc_valid=0, halted=1, pc holds; start=1 -> RUN exactly as REQ-017.
REQ-027 issue_cnt increments by 1 on every issue edge, including the halt/jump/branch issue itself.
- Saturates at all-ones; does not wrap.
REQ-028 start is ignored in RUN and BUBBLE.
REQ-029 Simultaneous start and rst_n=0: reset wins.
REQ-030 pc_valid is 0 in every cycle where state is not RUN.

Reset
REQ-031 rst_n=0 asynchronously forces state=IDLE, pc=0, pc_valid=0, halted=0, issue_cnt=0.
REQ-032 Reset mid-RUN or mid-BUBBLE discards any pending redirect; no output glitches to a non-reset value while rst_n=0.
REQ-033 First edge after rst_n deasserts: behaviour is per IDLE (REQ-017).

Verification
REQ-034 Sequential run: start, start_addr=16'h0010, stall=0, 4 edges.
- pc=10,11,12,13 with pc_valid=1 each cycle; issue_cnt=4.
REQ-035 Branch back: at pc=16'h0012, br_taken=1, br_offset=8'hFE.
- Next cycle pc=16'h0010, pc_valid=0.
- Following cycle pc=16'h0010, pc_valid=1.
REQ-036 Jump vs branch vs stall:
- jmp_en=1 and br_taken=1 on the same issue edge, jmp_target=16'h0100 -> pc=16'h0100.
- Same requests with stall=1 -> pc unchanged, no bubble.
REQ-037 Wrap and halt:
- start_addr=16'hFFFF, one issue -> pc=16'h0000.
- halt=1 -> halted=1, pc_valid=0, pc held.
- start -> RUN with issue_cnt=0.
REQ-038 Async reset: drop rst_n between clock edges during RUN at pc=16'h0040.
- All outputs zero immediately; first edge after release stays IDLE until start.
REQ-039 Saturation: CNT_W=4, 20 consecutive issues -> issue_cnt=4'hF and holds.

Source files
------------

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//   Instruction fetch sequencer. It walks a program counter through the
//   instruction ROM. It applies absolute jumps and relative branches with a
//   one-cycle bubble, stops on a halt request, and counts issued instructions.
//
// Ports
//   clk         in   rising-edge clock for all state
//   rst_n       in   asynchronous active-low reset
//   start       in   one-cycle pulse; starts execution from IDLE or HALTED
//   start_addr  in   initial pc, sampled when start is accepted
//   stall       in   downstream not ready; freezes pc, state and counter in RUN
//   jmp_en      in   absolute jump request (sampled on issue edges only)
//   jmp_target  in   jump destination
//   br_taken    in   taken relative branch request (sampled on issue edges only)
//   br_offset   in   signed 8-bit branch displacement
//   halt        in   halt request (sampled on issue edges only)
//   pc          out  address presented to the instruction ROM
//   pc_valid    out  pc is a live instruction address this cycle
//   halted      out  block sits in HALTED
//   issue_cnt   out  saturating count of issues since the last accepted start
// -----------------------------------------------------------------------------
module fetch_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [15:0]      start_addr,
   input  logic             stall,
   input  logic             jmp_en,
   input  logic [15:0]      jmp_target,
   input  logic             br_taken,
   input  logic [7:0]       br_offset,
   input  logic             halt,
   output logic [15:0]      pc,
   output logic             pc_valid,
   output logic             halted,
   output logic [CNT_W-1:0] issue_cnt
);

   typedef enum logic [1:0] {StIdle, StRun, StBubble, StHalted} state_e;

   state_e             r_state;
   logic [15:0]        r_pc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_pc_valid;
   logic               r_halted;

   state_e             w_state_nxt;
   logic [15:0]        w_pc_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_pc_valid_nxt;
   logic               w_halted_nxt;
   logic [15:0]        w_br_disp;
   logic [CNT_W-1:0]   w_cnt_inc;

   // Sign-extended branch displacement; the 16-bit add wraps modulo 2^16.
   assign w_br_disp = {{8{br_offset[7]}}, br_offset};

   // Counter saturates at all-ones instead of wrapping.
   assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

   // State register: all state and outputs are flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_pc       <= 16'h0000;
         r_cnt      <= '0;
         r_pc_valid <= 1'b0;
         r_halted   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_cnt      <= w_cnt_nxt;
         r_pc_valid <= w_pc_valid_nxt;
         r_halted   <= w_halted_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         StIdle, StHalted: begin
            if (start) begin
               w_state_nxt = StRun;
               w_pc_nxt    = start_addr;
               w_cnt_nxt   = '0;
            end
         end
         StRun: begin
            // Issue edge: the redirect inputs matter only when not stalled.
            if (!stall) begin
               w_cnt_nxt = w_cnt_inc;
               if (halt) begin
                  w_state_nxt = StHalted;
               end else if (jmp_en) begin
                  w_state_nxt = StBubble;
                  w_pc_nxt    = jmp_target;
               end else if (br_taken) begin
                  w_state_nxt = StBubble;
                  w_pc_nxt    = r_pc + w_br_disp;
               end else begin
                  w_pc_nxt    = r_pc + 16'd1;
               end
            end
         end
         StBubble: begin
            // The bubble always lasts exactly one cycle.
            w_state_nxt = StRun;
         end
      endcase
   end

   // Output logic: decoded from the next state so the flops present it in step.
   always_comb begin
      w_pc_valid_nxt = (w_state_nxt == StRun);
      w_halted_nxt   = (w_state_nxt == StHalted);
   end

   assign pc        = r_pc;
   assign pc_valid  = r_pc_valid;
   assign halted    = r_halted;
   assign issue_cnt = r_cnt;

endmodule
